// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush/forward control and retire tracking for a 5-stage in-order pipeline; build with PIPE_HAZARD_FORWARD_EN for bypassing.
// Zero-latency combinational stall/flush/forward; stage state advances every cycle, M->W never stalls, branch flush overrides stall.
module pipe_hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FetchValid,
    input  logic [PC_W-1:0]   PCF,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic              UsesRsD,
    input  logic              UsesRtD,
    input  logic [REG_W-1:0]  WriteRegD,
    input  logic              RegWriteD,
    input  logic              MemReadD,
    input  logic              BranchTakenE,
    input  logic [DATA_W-1:0] WriteDataW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              ValidE,
    output logic              ValidM,
    output logic              ValidW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              RetireValid,
    output logic [PC_W-1:0]   RetirePC,
    output logic [DATA_W-1:0] RetireData,
    output logic [CNT_W-1:0]  RetireCount
);

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] dest;
        logic             regwrite;
        logic             memread;
    } stage_t;

    typedef struct packed {
        stage_t           s;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
    } ex_t;

    logic             d_valid_q, d_valid_d;
    logic [PC_W-1:0]  d_pc_q, d_pc_d;
    ex_t              e_q, e_d;
    stage_t           m_q, w_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             stall;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    function automatic logic src_hit(input logic vld, input logic rw, input logic [REG_W-1:0] dst);
        return vld && rw && (dst != '0) &&
               ((UsesRsD && (RsD == dst)) || (UsesRtD && (RtD == dst)));
    endfunction

`ifdef PIPE_HAZARD_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input stage_t m, input stage_t w, input logic [REG_W-1:0] src);
        if (m.valid && m.regwrite && (m.dest != '0) && (m.dest == src)) return 2'b10;
        if (w.valid && w.regwrite && (w.dest != '0) && (w.dest == src)) return 2'b01;
        return 2'b00;
    endfunction

    // Only a load still in Execute cannot be bypassed in time.
    assign hazard    = d_valid_q && e_q.s.memread &&
                       src_hit(e_q.s.valid, e_q.s.regwrite, e_q.s.dest);
    assign ForwardAE = fwd_sel(m_q, w_q, e_q.rs);
    assign ForwardBE = fwd_sel(m_q, w_q, e_q.rt);
`else
    assign hazard    = d_valid_q &&
                       (src_hit(e_q.s.valid, e_q.s.regwrite, e_q.s.dest) ||
                        src_hit(m_q.valid, m_q.regwrite, m_q.dest) ||
                        src_hit(w_q.valid, w_q.regwrite, w_q.dest));
    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;
`endif

    assign stall  = hazard && !BranchTakenE;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = BranchTakenE;
    assign FlushE = BranchTakenE;

    always_comb begin
        d_valid_d = d_valid_q;
        d_pc_d    = d_pc_q;
        e_d       = '0;
        cnt_d     = cnt_q;
        if (BranchTakenE) begin
            d_valid_d = 1'b0;
        end else if (!stall) begin
            d_valid_d = FetchValid;
            d_pc_d    = PCF;
        end
        // Bubbles and squashed slots carry all-zero fields so they never match a source.
        if (!BranchTakenE && !stall && d_valid_q) begin
            e_d.s.valid    = 1'b1;
            e_d.s.pc       = d_pc_q;
            e_d.s.dest     = WriteRegD;
            e_d.s.regwrite = RegWriteD;
            e_d.s.memread  = MemReadD;
            e_d.rs         = RsD;
            e_d.rt         = RtD;
            e_d.use_rs     = UsesRsD;
            e_d.use_rt     = UsesRtD;
        end
        if (w_q.valid) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= '0;
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            cnt_q     <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_pc_q    <= d_pc_d;
            e_q       <= e_d;
            m_q       <= e_q.s;
            w_q       <= m_q;
            cnt_q     <= cnt_d;
        end
    end

    assign ValidE      = e_q.s.valid;
    assign ValidM      = m_q.valid;
    assign ValidW      = w_q.valid;
    assign RetireValid = w_q.valid;
    assign RetirePC    = w_q.valid ? w_q.pc : '0;
    assign RetireData  = w_q.valid ? WriteDataW : '0;
    assign RetireCount = cnt_q;

endmodule
